wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 52 +++++
 tb/tb_wb_regfile.sv | 126 ++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage of the MEM/WB register plus the architectural register file.
// Selects load or ALU data, commits it with r0 hardwired to zero, and bypasses same-cycle writes to the read ports.
module wb_regfile #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            WB_RegW,
    input  logic            WB_Reg_Src,
    input  logic [AW-1:0]   WB_WBdst,
    input  logic [DW-1:0]   WB_DataMem,
    input  logic [DW-1:0]   WB_Alu_C,
    input  logic [AW-1:0]   ID_Rs,
    input  logic [AW-1:0]   ID_Rt,
    output logic [DW-1:0]   ID_RsData,
    output logic [DW-1:0]   ID_RtData,
    output logic [DW-1:0]   WB_WrData,
    output logic [CNTW-1:0] WB_WrCnt
);

    localparam int NREG = 2**AW;

    logic [DW-1:0] regs [NREG];
    logic          commit;

    assign WB_WrData = WB_Reg_Src ? WB_DataMem : WB_Alu_C;
    assign commit    = WB_RegW && (WB_WBdst != '0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            WB_WrCnt <= '0;
        end else if (commit) begin
            regs[WB_WBdst] <= WB_WrData;
            WB_WrCnt       <= WB_WrCnt + CNTW'(1);
        end
    end

    // r0 and reset win over the bypass; a committing write is forwarded before it lands in storage
    function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
        if (a == '0)                      return '0;
        else if (rst)                     return '0;
        else if (commit && a == WB_WBdst) return WB_WrData;
        else                              return regs[a];
    endfunction

    assign ID_RsData = rd_port(ID_Rs);
    assign ID_RtData = rd_port(ID_Rt);

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized bench for wb_regfile against an array-based model of the register file.
// The counter is narrowed so wrap-around is reached within the random phase.
module tb_wb_regfile;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            WB_RegW = 1'b0;
    logic            WB_Reg_Src = 1'b0;
    logic [AW-1:0]   WB_WBdst = '0;
    logic [DW-1:0]   WB_DataMem = '0;
    logic [DW-1:0]   WB_Alu_C = '0;
    logic [AW-1:0]   ID_Rs = '0;
    logic [AW-1:0]   ID_Rt = '0;
    logic [DW-1:0]   ID_RsData;
    logic [DW-1:0]   ID_RtData;
    logic [DW-1:0]   WB_WrData;
    logic [CNTW-1:0] WB_WrCnt;

    wb_regfile #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .WB_RegW(WB_RegW), .WB_Reg_Src(WB_Reg_Src), .WB_WBdst(WB_WBdst),
        .WB_DataMem(WB_DataMem), .WB_Alu_C(WB_Alu_C),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
        .WB_WrData(WB_WrData), .WB_WrCnt(WB_WrCnt)
    );

    always #5 clk = ~clk;

    // reference state: architectural registers and commit count
    logic [DW-1:0] ref_regs [32];
    int            ref_cnt;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(input int a, input logic r, input logic we,
                                               input int d, input logic [DW-1:0] wd);
        if (a == 0) return '0;
        if (r) return '0;
        if (we && d != 0 && a == d) return wd;
        return ref_regs[a];
    endfunction

    // one cycle: drive after negedge, check read ports mid-cycle, update model at posedge, check counter after
    task automatic step(input string tag, input logic r, input logic we, input logic src,
                        input int d, input logic [DW-1:0] dm, input logic [DW-1:0] alu,
                        input int rs, input int rt);
        logic [DW-1:0] wd;
        @(negedge clk);
        rst = r; WB_RegW = we; WB_Reg_Src = src; WB_WBdst = AW'(d);
        WB_DataMem = dm; WB_Alu_C = alu; ID_Rs = AW'(rs); ID_Rt = AW'(rt);
        wd = src ? dm : alu;
        #1;
        chk({tag, ".wrdata"}, WB_WrData, wd);
        chk({tag, ".rs"}, ID_RsData, ref_read(rs, r, we, d, wd));
        chk({tag, ".rt"}, ID_RtData, ref_read(rt, r, we, d, wd));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = '0;
            ref_cnt = 0;
        end else if (we && d != 0) begin
            ref_regs[d] = wd;
            ref_cnt = (ref_cnt + 1) % (2**CNTW);
        end
        #1;
        chk({tag, ".cnt"}, DW'(WB_WrCnt), DW'(ref_cnt));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        ref_cnt = 0;

        step("t1_reset", 1, 0, 0, 0, 0, 0, 5, 31);
        step("t1_read", 0, 0, 0, 0, 0, 0, 5, 31);
        chk("t1_cnt0", DW'(WB_WrCnt), 32'd0);

        step("t2_alu", 0, 1, 0, 3, 32'hDEAD_BEEF, 32'h1234_5678, 3, 0);
        step("t2_store", 0, 0, 0, 0, 0, 0, 3, 3);
        chk("t2_r3", ID_RsData, 32'h1234_5678);
        chk("t2_cnt1", DW'(WB_WrCnt), 32'd1);

        step("t3_load", 0, 1, 1, 7, 32'hCAFE_0001, 32'h0BAD_F00D, 3, 7);
        step("t3_store", 0, 0, 0, 0, 0, 0, 7, 7);
        chk("t3_r7", ID_RtData, 32'hCAFE_0001);

        step("t4_r0", 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
        chk("t4_cnt", DW'(WB_WrCnt), 32'd2);

        step("t5_pre", 0, 1, 0, 9, 0, 32'h1111_2222, 9, 9);
        step("t5_dual", 0, 1, 0, 9, 0, 32'h3333_4444, 9, 9);
        step("t5_noweq", 0, 0, 0, 9, 0, 32'h5555_6666, 9, 9);

        step("t6_wr4", 0, 1, 0, 4, 0, 32'hA5A5_A5A5, 4, 9);
        step("t6_rst", 1, 1, 0, 4, 0, 32'h0000_0001, 4, 9);
        step("t6_after", 0, 0, 0, 0, 0, 0, 4, 9);
        chk("t6_cnt0", DW'(WB_WrCnt), 32'd0);

        for (int n = 0; n < 300; n++) begin
            logic r, we, src;
            int d, rs, rt;
            r   = ($urandom_range(0, 39) == 0);
            we  = ($urandom_range(0, 3) != 0);
            src = 1'($urandom);
            d   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 31);
            rs  = ($urandom_range(0, 2) == 0) ? d : $urandom_range(0, 31);
            rt  = ($urandom_range(0, 2) == 0) ? d : $urandom_range(0, 31);
            step("rand", r, we, src, d, $urandom, $urandom, rs, rt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
